ov7670_capture: RTL and testbench

Camera capture stage between the OV7670 parallel bus and the camera frame buffer. It samples the camera pixel clock, syncs and data in the system clock domain and packs byte pairs into 12-bit RGB444 pixels. It writes each pixel to the frame buffer's write port (address, data, write enable) in raster order, clipped to the configured image size. It reports each completed frame.

---
 rtl/ov7670_capture_if.sv | 13 +
 rtl/ov7670_capture.sv | 151 +++++++++++++++
 tb/tb_ov7670_capture.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_capture_if.sv
// Frame-buffer write port driven by the OV7670 capture stage.
// The master drives address, data and strobe; the frame buffer is the slave.
interface ov7670_capture_if #(
    parameter int c_nb_img_pxls = 15,
    parameter int c_nb_buf      = 12
);
    logic [c_nb_img_pxls-1:0] capture_addr;
    logic [c_nb_buf-1:0]      capture_data;
    logic                     capture_we;

    modport master (output capture_addr, output capture_data, output capture_we);
    modport slave  (input  capture_addr, input  capture_data, input  capture_we);
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus capture: synchronises the camera bus into clk, packs byte
// pairs into RGB444 pixels and writes them in raster order, clipped to the image size.
module ov7670_capture #(
    parameter int c_img_cols    = 160,
    parameter int c_img_rows    = 120,
    parameter int c_nb_img_pxls = 15,
    parameter int c_nb_buf      = 12,
    parameter bit c_swap_rb     = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_capture_en,
    input  logic                     i_cam_pclk,
    input  logic                     i_cam_vsync,
    input  logic                     i_cam_href,
    input  logic [7:0]               i_cam_data,
    ov7670_capture_if.master         fb,
    output logic                     o_frame_done,
    output logic                     o_busy
);
    localparam int lp_col_w = $clog2(c_img_cols + 1);
    localparam int lp_row_w = $clog2(c_img_rows + 1);
    localparam logic [lp_col_w-1:0] lp_cols = lp_col_w'(c_img_cols);
    localparam logic [lp_row_w-1:0] lp_rows = lp_row_w'(c_img_rows);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_WAIT_START,
        ST_ACTIVE
    } state_t;

    // Bus bundle: [0]=pclk, [1]=href, [2]=vsync, [10:3]=data
    logic [10:0] w_cam_in;
    logic [10:0] r_meta;
    logic [10:0] r_sync;
    logic [10:0] r_dly;
    logic        r_pix_stb;

    assign w_cam_in = {i_cam_data, i_cam_vsync, i_cam_href, i_cam_pclk};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta    <= '0;
            r_sync    <= '0;
            r_dly     <= '0;
            r_pix_stb <= 1'b0;
        end else begin
            r_meta    <= w_cam_in;
            r_sync    <= r_meta;
            r_dly     <= r_sync;
            r_pix_stb <= r_sync[0] & ~r_dly[0];
        end
    end

    // r_pix_stb lags r_sync by one clk, so the byte and href seen with it come from r_dly.
    logic       w_href_q;
    logic       w_href_fall;
    logic       w_vs_rise;
    logic       w_vs_fall;
    logic [7:0] w_byte;

    assign w_href_q    = r_dly[1];
    assign w_href_fall = r_dly[1] & ~r_sync[1];
    assign w_vs_rise   = r_sync[2] & ~r_dly[2];
    assign w_vs_fall   = ~r_sync[2] & r_dly[2];
    assign w_byte      = r_dly[10:3];

    state_t                   r_state;
    logic [lp_col_w-1:0]      r_col;
    logic [lp_row_w-1:0]      r_row;
    logic [c_nb_img_pxls-1:0] r_addr;
    logic                     r_phase;
    logic [3:0]               r_red;
    logic [c_nb_img_pxls-1:0] r_addr_out;
    logic [c_nb_buf-1:0]      r_data_out;
    logic                     r_we;
    logic                     r_frame_done;
    logic [11:0]              w_pix;

    assign w_pix = c_swap_rb ? {w_byte[3:0], w_byte[7:4], r_red}
                             : {r_red, w_byte[7:4], w_byte[3:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_addr       <= '0;
            r_phase      <= 1'b0;
            r_red        <= '0;
            r_addr_out   <= '0;
            r_data_out   <= '0;
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_capture_en) r_state <= ST_WAIT_VS;
                end
                ST_WAIT_VS: begin
                    if (r_sync[2]) r_state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (w_vs_fall) begin
                        r_state <= ST_ACTIVE;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_addr  <= '0;
                        r_phase <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_vs_rise) begin
                        r_frame_done <= 1'b1;
                        r_phase      <= 1'b0;
                        r_state      <= i_capture_en ? ST_WAIT_START : ST_IDLE;
                    end else if (w_href_fall) begin
                        // A pending first byte of a pixel is dropped here.
                        r_col   <= '0;
                        r_phase <= 1'b0;
                        if (r_row < lp_rows) r_row <= r_row + lp_row_w'(1);
                    end else if (r_pix_stb && w_href_q) begin
                        if (!r_phase) begin
                            r_red   <= w_byte[3:0];
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            if (r_col < lp_cols && r_row < lp_rows) begin
                                r_we       <= 1'b1;
                                r_addr_out <= r_addr;
                                r_data_out <= w_pix;
                                r_addr     <= r_addr + c_nb_img_pxls'(1);
                            end
                            if (r_col < lp_cols) r_col <= r_col + lp_col_w'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign fb.capture_addr = r_addr_out;
    assign fb.capture_data = r_data_out;
    assign fb.capture_we   = r_we;
    assign o_frame_done    = r_frame_done;
    assign o_busy          = (r_state == ST_ACTIVE);
endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a 6x4 image with pclk = clk/4.
// A negedge monitor tallies writes; the main sequence asserts on the tallies.
module tb_ov7670_capture;
    localparam int C_COLS = 6;
    localparam int C_ROWS = 4;
    localparam int C_AW   = 5;
    localparam int C_NPIX = C_COLS * C_ROWS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cam_en;
    logic       cam_pclk;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;
    logic       frame_done;
    logic       busy;

    ov7670_capture_if #(.c_nb_img_pxls(C_AW), .c_nb_buf(12)) fb_if ();

    ov7670_capture #(
        .c_img_cols(C_COLS), .c_img_rows(C_ROWS), .c_nb_img_pxls(C_AW),
        .c_nb_buf(12), .c_swap_rb(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_capture_en(cam_en),
        .i_cam_pclk(cam_pclk), .i_cam_vsync(cam_vsync), .i_cam_href(cam_href),
        .i_cam_data(cam_data), .fb(fb_if), .o_frame_done(frame_done), .o_busy(busy)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor tallies and the expectation it checks each written pixel against
    int         wr_cnt, addr_err, data_err, we_long, fd_cnt, fd_with_we, wr_at_fd;
    int         last_addr, first_addr;
    logic [C_AW-1:0] exp_addr;
    logic       we_prev = 1'b0;
    bit         r_idx;
    logic [3:0] r_fix;
    logic [7:0] gb;

    always @(negedge clk) begin
        logic [3:0] er;
        if (fb_if.capture_we) begin
            if (wr_cnt == 0) first_addr = int'(fb_if.capture_addr);
            wr_cnt++;
            last_addr = int'(fb_if.capture_addr);
            if (fb_if.capture_addr !== exp_addr) addr_err++;
            exp_addr = fb_if.capture_addr + C_AW'(1);
            er = r_idx ? 4'(int'(fb_if.capture_addr) % C_COLS) : r_fix;
            if (fb_if.capture_data !== {gb[3:0], gb[7:4], er}) data_err++;
            if (we_prev) we_long++;
        end
        we_prev = fb_if.capture_we;
        if (frame_done) begin
            fd_cnt++;
            wr_at_fd = wr_cnt;
            if (fb_if.capture_we) fd_with_we++;
        end
    end

    task automatic clear_tally();
        wr_cnt = 0; addr_err = 0; data_err = 0; we_long = 0;
        fd_cnt = 0; fd_with_we = 0; wr_at_fd = -1; last_addr = -1; first_addr = -1;
        exp_addr = '0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cam_byte(input logic [7:0] b);
        cam_pclk = 1'b0;
        cam_data = b;
        tick(2);
        cam_pclk = 1'b1;
        tick(2);
    endtask

    // Even bytes carry R in the low nibble (the pixel index when idx=1); odd bytes are gb.
    task automatic cam_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1, input bit idx);
        logic [7:0] b;
        cam_href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            if (i % 2 == 0) begin
                b = b0;
                if (idx) b[3:0] = 4'(i / 2);
            end else begin
                b = b1;
            end
            cam_byte(b);
        end
        cam_pclk = 1'b0;
        tick(2);
        cam_href = 1'b0;
        tick(6);
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        tick(10);
        cam_vsync = 1'b0;
        tick(10);
    endtask

    task automatic cam_frame(input int nlines, input int nbytes, input logic [7:0] b0, input logic [7:0] b1, input bit idx);
        for (int l = 0; l < nlines; l++) cam_line(nbytes, b0, b1, idx);
        vsync_pulse();
    endtask

    initial begin
        clear_tally();
        r_idx = 1'b0; r_fix = 4'hA; gb = 8'h5C;
        rst_n = 1'b0; cam_en = 1'b1;
        cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;

        // Reset held with random camera activity
        for (int i = 0; i < 40; i++) begin
            cam_pclk  = 1'($urandom_range(1));
            cam_vsync = 1'($urandom_range(1));
            cam_href  = 1'($urandom_range(1));
            cam_data  = 8'($urandom_range(255));
            tick(2);
        end
        chk("rst_addr", int'(fb_if.capture_addr), 0);
        chk("rst_data", int'(fb_if.capture_data), 0);
        chk("rst_we",   int'(fb_if.capture_we), 0);
        chk("rst_fd",   int'(frame_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_cnt", wr_cnt, 0);

        // Released with capture disabled: two frames, no writes
        cam_en = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        clear_tally();
        vsync_pulse();
        cam_frame(C_ROWS, 2 * C_COLS, 8'h0A, 8'h5C, 1'b0);
        cam_frame(C_ROWS, 2 * C_COLS, 8'h0A, 8'h5C, 1'b0);
        chk("dis_wr_cnt", wr_cnt, 0);
        chk("dis_fd_cnt", fd_cnt, 0);
        chk("dis_busy", int'(busy), 0);

        // Nominal frame: bytes 0x0A,0x5C -> 0xC5A at addresses 0..23
        cam_en = 1'b1;
        tick(2);
        vsync_pulse();
        chk("nom_busy", int'(busy), 1);
        clear_tally();
        cam_frame(C_ROWS, 2 * C_COLS, 8'h0A, 8'h5C, 1'b0);
        chk("nom_wr_cnt", wr_cnt, C_NPIX);
        chk("nom_first", first_addr, 0);
        chk("nom_last", last_addr, C_NPIX - 1);
        chk("nom_addr_err", addr_err, 0);
        chk("nom_data_err", data_err, 0);
        chk("nom_we_long", we_long, 0);
        chk("nom_fd_cnt", fd_cnt, 1);
        chk("nom_wr_at_fd", wr_at_fd, C_NPIX);
        chk("nom_fd_with_we", fd_with_we, 0);
        chk("nom_hold_addr", int'(fb_if.capture_addr), C_NPIX - 1);
        chk("nom_hold_data", int'(fb_if.capture_data), 32'hC5A);

        // Oversize frame: 8 px x 5 lines, R nibble = column index
        r_idx = 1'b1; gb = 8'h9E;
        clear_tally();
        cam_frame(C_ROWS + 1, 2 * (C_COLS + 2), 8'hF0, 8'h9E, 1'b1);
        chk("ovr_wr_cnt", wr_cnt, C_NPIX);
        chk("ovr_last", last_addr, C_NPIX - 1);
        chk("ovr_addr_err", addr_err, 0);
        chk("ovr_data_err", data_err, 0);
        chk("ovr_fd_cnt", fd_cnt, 1);

        // Odd byte count per line: trailing byte dropped, next line starts at phase 0
        gb = 8'h37;
        clear_tally();
        cam_frame(C_ROWS, 2 * C_COLS + 1, 8'hF0, 8'h37, 1'b1);
        chk("odd_wr_cnt", wr_cnt, C_NPIX);
        chk("odd_addr_err", addr_err, 0);
        chk("odd_data_err", data_err, 0);

        // Vsync after 2 lines, then a full frame restarting at address 0
        clear_tally();
        cam_frame(2, 2 * C_COLS, 8'hF0, 8'h37, 1'b1);
        chk("mid_wr_cnt", wr_cnt, 2 * C_COLS);
        chk("mid_fd_cnt", fd_cnt, 1);
        chk("mid_wr_at_fd", wr_at_fd, 2 * C_COLS);
        clear_tally();
        cam_frame(C_ROWS, 2 * C_COLS, 8'hF0, 8'h37, 1'b1);
        chk("restart_first", first_addr, 0);
        chk("restart_wr_cnt", wr_cnt, C_NPIX);
        chk("restart_addr_err", addr_err, 0);

        // capture_en dropped mid-frame: frame completes, then idle
        clear_tally();
        cam_line(2 * C_COLS, 8'hF0, 8'h37, 1'b1);
        cam_line(2 * C_COLS, 8'hF0, 8'h37, 1'b1);
        cam_en = 1'b0;
        cam_frame(C_ROWS - 2, 2 * C_COLS, 8'hF0, 8'h37, 1'b1);
        chk("en_drop_wr_cnt", wr_cnt, C_NPIX);
        chk("en_drop_fd_cnt", fd_cnt, 1);
        chk("en_drop_busy", int'(busy), 0);
        clear_tally();
        cam_frame(C_ROWS, 2 * C_COLS, 8'hF0, 8'h37, 1'b1);
        chk("en_drop_next_wr", wr_cnt, 0);
        chk("en_drop_next_fd", fd_cnt, 0);

        // Reset asserted mid-line
        cam_en = 1'b1;
        tick(2);
        vsync_pulse();
        clear_tally();
        cam_line(2 * C_COLS, 8'hF0, 8'h37, 1'b1);
        cam_href = 1'b1;
        for (int i = 0; i < 4; i++) cam_byte((i % 2 == 0) ? 8'(8'hF0 + i / 2) : 8'h37);
        cam_pclk = 1'b0;
        tick(3);
        chk("mrst_wr_before", wr_cnt, C_COLS + 2);
        rst_n = 1'b0;
        tick(1);
        chk("mrst_addr", int'(fb_if.capture_addr), 0);
        chk("mrst_data", int'(fb_if.capture_data), 0);
        chk("mrst_busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) cam_byte(8'h37);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cam_byte(8'h37);
        cam_pclk = 1'b0;
        tick(2);
        cam_href = 1'b0;
        tick(6);
        chk("mrst_wr_after", wr_cnt, C_COLS + 2);
        chk("mrst_busy_after", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
